// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / redirect controller for a six-stage in-order pipe.
//
// Ports
//   clk_i, rst_i        single clock; synchronous active-high reset
//   stallreq_id_i       load-use hazard seen in ID
//   stallreq_ex_i       multi-cycle EX operation still busy
//   branch_i            taken branch/jump resolved in EX this cycle
//   branch_target_i     redirect address, valid with branch_i
//   stall_o[5:0]        per-stage hold {WB,MEM,EX,ID,IF,PC}, 1 = stop (combinational)
//   flush_o             squash IF/ID contents while the flush window is open
//   redirect_o          one-cycle PC load strobe, the cycle after a branch is accepted
//   redirect_pc_o       PC load value, valid with redirect_o, held otherwise
//   timeout_o           sticky: EX stalled MAX_STALL consecutive cycles
//   load_stall_cnt_o    saturating count of load-use stall cycles
//   ex_stall_cnt_o      saturating count of EX stall cycles
//   dbg_state_o         current FSM state (RUN=0, EX_WAIT=1, FLUSH=2)
//
// Request/strobe semantics: the request inputs are level-sensitive and sampled
// every cycle with no handshake. A branch is accepted in any cycle where
// branch_i=1 and stallreq_ex_i=0; while EX is busy the branch is ignored and
// the EX stage is expected to present it again once it releases. redirect_o
// is a single-cycle strobe with no back-pressure.
module pipe_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stallreq_id_i,
    input  logic                  stallreq_ex_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    output logic [5:0]            stall_o,
    output logic                  flush_o,
    output logic                  redirect_o,
    output logic [ADDR_WIDTH-1:0] redirect_pc_o,
    output logic                  timeout_o,
    output logic [CNT_WIDTH-1:0]  load_stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  ex_stall_cnt_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        EX_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD    = 3'(FLUSH_CYCLES);
    localparam logic [7:0] MAX_STALL_L   = 8'(MAX_STALL);
    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_LOADUSE = 6'b000111;
    localparam logic [5:0] STALL_EX      = 6'b001111;

    state_t     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] ex_run_q, ex_run_d;
    logic       accept;

    assign accept      = branch_i & ~stallreq_ex_i;
    assign flush_o     = (state_q == FLUSH);
    assign dbg_state_o = state_q;

    // Next-state logic. A branch acceptance overrides every other transition
    // and (re)opens the flush window, including when already in FLUSH.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (stallreq_ex_i) state_d = EX_WAIT;
            end
            EX_WAIT: begin
                if (!stallreq_ex_i) state_d = RUN;
            end
            FLUSH: begin
                // The window keeps draining even if EX stalls meanwhile.
                if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = stallreq_ex_i ? EX_WAIT : RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = 3'd0;
            end
        endcase
        if (accept) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
        end
    end

    // Stage holds. The instruction in ID is squashed during FLUSH and by a
    // branch resolving this cycle, so its load-use request must not stall.
    always_comb begin
        stall_o = STALL_NONE;
        if (rst_i)                               stall_o = STALL_NONE;
        else if (stallreq_ex_i)                  stall_o = STALL_EX;
        else if (state_q == FLUSH || branch_i)   stall_o = STALL_NONE;
        else if (stallreq_id_i)                  stall_o = STALL_LOADUSE;
    end

    // Consecutive EX-stall run length, saturating so a long stall cannot wrap.
    always_comb begin
        ex_run_d = 8'd0;
        if (stallreq_ex_i) ex_run_d = (ex_run_q == 8'hFF) ? 8'hFF : ex_run_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= RUN;
            flush_cnt_q      <= 3'd0;
            redirect_o       <= 1'b0;
            redirect_pc_o    <= '0;
            timeout_o        <= 1'b0;
            ex_run_q         <= 8'd0;
            load_stall_cnt_o <= '0;
            ex_stall_cnt_o   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            redirect_o  <= accept;
            if (accept) redirect_pc_o <= branch_target_i;
            ex_run_q <= ex_run_d;
            if (ex_run_d >= MAX_STALL_L) timeout_o <= 1'b1;
            if (stall_o == STALL_LOADUSE && load_stall_cnt_o != '1)
                load_stall_cnt_o <= load_stall_cnt_o + 1'b1;
            if (stall_o == STALL_EX && ex_stall_cnt_o != '1)
                ex_stall_cnt_o <= ex_stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int AW     = 32;
    localparam int FC     = 2;
    localparam int MS     = 64;
    localparam int CW     = 6;
    localparam int CNTMAX = (1 << CW) - 1;

    // ---- clock / reset ----
    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          stallreq_id_i = 1'b0;
    logic          stallreq_ex_i = 1'b0;
    logic          branch_i = 1'b0;
    logic [AW-1:0] branch_target_i = '0;
    logic [5:0]    stall_o;
    logic          flush_o;
    logic          redirect_o;
    logic [AW-1:0] redirect_pc_o;
    logic          timeout_o;
    logic [CW-1:0] load_stall_cnt_o;
    logic [CW-1:0] ex_stall_cnt_o;
    logic [1:0]    dbg_state_o;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(
        .ADDR_WIDTH  (AW),
        .FLUSH_CYCLES(FC),
        .MAX_STALL   (MS),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .timeout_o       (timeout_o),
        .load_stall_cnt_o(load_stall_cnt_o),
        .ex_stall_cnt_o  (ex_stall_cnt_o),
        .dbg_state_o     (dbg_state_o)
    );

    // ---- scoreboard / reference model ----
    int errors = 0;
    int checks = 0;

    int          m_flush_left = 0;   // cycles of flush window still to show
    logic        m_redirect   = 1'b0;
    logic [31:0] m_pc         = '0;
    logic        m_timeout    = 1'b0;
    int          m_run_len    = 0;   // consecutive EX-stall cycles
    int          m_ld         = 0;
    int          m_ex         = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---- driver: one clock cycle of stimulus, checked before and after the edge ----
    task automatic step(input logic r, input logic ex, input logic id, input logic br,
                        input logic [31:0] tgt);
        logic [5:0] exp_stall;
        rst_i = r; stallreq_ex_i = ex; stallreq_id_i = id;
        branch_i = br; branch_target_i = tgt;
        #1;
        if (r)                            exp_stall = 6'b000000;
        else if (ex)                      exp_stall = 6'b001111;
        else if (m_flush_left > 0 || br)  exp_stall = 6'b000000;
        else if (id)                      exp_stall = 6'b000111;
        else                              exp_stall = 6'b000000;
        chk("stall_o", {26'd0, stall_o}, {26'd0, exp_stall});

        @(posedge clk_i);
        if (r) begin
            m_flush_left = 0; m_redirect = 1'b0; m_pc = '0;
            m_timeout = 1'b0; m_run_len = 0; m_ld = 0; m_ex = 0;
        end else begin
            m_redirect = br && !ex;
            if (m_redirect) begin
                m_pc = tgt;
                m_flush_left = FC;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
            m_run_len = ex ? ((m_run_len < 255) ? m_run_len + 1 : 255) : 0;
            if (m_run_len >= MS) m_timeout = 1'b1;
            if (exp_stall == 6'b000111 && m_ld < CNTMAX) m_ld++;
            if (exp_stall == 6'b001111 && m_ex < CNTMAX) m_ex++;
        end
        #1;
        chk("flush_o",    {31'd0, flush_o},    {31'd0, m_flush_left > 0});
        chk("redirect_o", {31'd0, redirect_o}, {31'd0, m_redirect});
        chk("redirect_pc_o", redirect_pc_o, m_pc);
        chk("timeout_o",  {31'd0, timeout_o},  {31'd0, m_timeout});
        chk("load_stall_cnt_o", {26'd0, load_stall_cnt_o}, m_ld);
        chk("ex_stall_cnt_o",   {26'd0, ex_stall_cnt_o},   m_ex);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // ---- directed then random stimulus ----
    initial begin
        // Reset with requests active: stall must be forced low.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("reset_flush",    {31'd0, flush_o},    32'd0);
        chk("reset_redirect", {31'd0, redirect_o}, 32'd0);
        chk("reset_pc",       redirect_pc_o,       32'd0);

        // Single load-use stall in RUN.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("ld_cnt_one", {26'd0, load_stall_cnt_o}, 32'd1);
        idle(1);

        // Branch to 0x100: redirect next cycle, two flush cycles, then RUN.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        chk("br_redirect", {31'd0, redirect_o}, 32'd1);
        chk("br_pc",       redirect_pc_o,       32'h100);
        idle(1);
        chk("br_flush2", {31'd0, flush_o}, 32'd1);
        idle(1);
        chk("br_flush_end", {31'd0, flush_o}, 32'd0);

        // Load-use request during FLUSH is suppressed.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("flush_ld_unchanged", {26'd0, load_stall_cnt_o}, 32'd1);

        // Branch during FLUSH re-pulses redirect and reloads the window.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
        chk("rebranch_pc", redirect_pc_o, 32'h400);
        idle(3);

        // Branch while EX busy is ignored, then taken on re-presentation.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0500);
        chk("ex_br_ignored", {31'd0, redirect_o}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0500);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500);
        chk("ex_br_taken", redirect_pc_o, 32'h500);
        idle(3);

        // Long EX stall: timeout at the 64th cycle, perf counter saturates.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("timeout_at_63", {31'd0, timeout_o}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("timeout_at_64", {31'd0, timeout_o}, 32'd1);
        chk("ex_cnt_sat", {26'd0, ex_stall_cnt_o}, CNTMAX);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle(3);
        chk("timeout_sticky", {31'd0, timeout_o}, 32'd1);

        // Reset mid-FLUSH with EX busy: nothing resumes afterwards.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0600);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        idle(1);
        chk("rst_no_flush",    {31'd0, flush_o},    32'd0);
        chk("rst_no_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rst_timeout_clr", {31'd0, timeout_o},  32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < 20),
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
